// File: rtl/da_accum_pkg.sv
// Shared constants and FSM encoding for the distributed-arithmetic accumulator.
package da_accum_pkg;

    localparam int LUT_W     = 19;
    localparam int DATA_W    = 16;
    localparam int OUT_W     = LUT_W + 3 + DATA_W;
    localparam int N_BANKS   = 8;
    localparam int LUT_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/da_lut_bank.sv
// One 256-entry DA lookup bank: single write port, registered read.
// Storage has no reset so coefficients survive a system reset.
module da_lut_bank #(
    parameter int LUT_W = da_accum_pkg::LUT_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic [7:0]       waddr_i,
    input  logic [LUT_W-1:0] wdata_i,
    input  logic             re_i,
    input  logic [7:0]       raddr_i,
    output logic [LUT_W-1:0] rdata_o
);
    import da_accum_pkg::*;

    logic [LUT_W-1:0] mem_q [LUT_DEPTH];
    logic [LUT_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register doubles as pipeline stage 1; it holds while re_i is low.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/da_accum.sv
// Bit-serial distributed-arithmetic accumulator: 8 LUT banks, MSB-first
// bit-planes, two pipeline stages and an output register.
module da_accum #(
    parameter int LUT_W  = da_accum_pkg::LUT_W,
    parameter int DATA_W = da_accum_pkg::DATA_W,
    parameter int OUT_W  = da_accum_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             bit_valid,
    input  logic [7:0]       A7,
    input  logic [7:0]       A6,
    input  logic [7:0]       A5,
    input  logic [7:0]       A4,
    input  logic [7:0]       A3,
    input  logic [7:0]       A2,
    input  logic [7:0]       A1,
    input  logic [7:0]       A0,
    input  logic             lut_we,
    input  logic [2:0]       lut_sel,
    input  logic [7:0]       lut_addr,
    input  logic [LUT_W-1:0] lut_wdata,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    output logic             busy
);
    import da_accum_pkg::*;

    localparam int             CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(DATA_W - 1);

    state_e           state_q;
    logic [CNT_W-1:0] plane_q;
    logic             v1_q, first1_q, last1_q;
    logic             v2_q;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] y_q;
    logic             y_valid_q;

    logic [7:0]       addr  [N_BANKS];
    logic [LUT_W-1:0] ent   [N_BANKS];
    logic [OUT_W-1:0] sum_d;
    logic             accept;

    assign addr[0] = A0;
    assign addr[1] = A1;
    assign addr[2] = A2;
    assign addr[3] = A3;
    assign addr[4] = A4;
    assign addr[5] = A5;
    assign addr[6] = A6;
    assign addr[7] = A7;

    // start wins over a coincident bit_valid: the first plane follows the load.
    assign accept = (state_q == ACCUM) && bit_valid && !start;

    for (genvar k = 0; k < N_BANKS; k++) begin : g_bank
        da_lut_bank #(.LUT_W(LUT_W)) u_bank (
            .clk_i   (clk),
            .rst_n_i (resetn),
            .we_i    (lut_we && !busy && (lut_sel == 3'(k))),
            .waddr_i (lut_addr),
            .wdata_i (lut_wdata),
            .re_i    (accept),
            .raddr_i (addr[k]),
            .rdata_o (ent[k])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < N_BANKS; k++) begin
            sum_d = sum_d + {{(OUT_W-LUT_W){ent[k][LUT_W-1]}}, ent[k]};
        end
    end

    // Sign plane carries negative weight; later planes shift-and-add.
    always_comb begin
        acc_d = acc_q;
        if (start) begin
            acc_d = '0;
        end else if (v1_q) begin
            acc_d = first1_q ? (-sum_d) : ((acc_q << 1) + sum_d);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            plane_q   <= '0;
            v1_q      <= 1'b0;
            first1_q  <= 1'b0;
            last1_q   <= 1'b0;
            v2_q      <= 1'b0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACCUM;
                        plane_q <= '0;
                    end
                end
                ACCUM: begin
                    if (start) begin
                        plane_q <= '0;
                    end else if (bit_valid) begin
                        if (plane_q == LAST_PLANE) begin
                            plane_q <= '0;
                            state_q <= FLUSH;
                        end else begin
                            plane_q <= plane_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (start) begin
                        state_q <= ACCUM;
                        plane_q <= '0;
                    end else if (v2_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            v1_q <= accept;
            if (accept) begin
                first1_q <= (plane_q == '0);
                last1_q  <= (plane_q == LAST_PLANE);
            end
            v2_q  <= v1_q && last1_q && !start;
            acc_q <= acc_d;
            if (v2_q && !start) begin
                y_q       <= acc_q;
                y_valid_q <= 1'b1;
            end
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: doc/da_accum.md
DA_ACCUM -- requirements
Module: da_accum

Interface
REQ-001 The block SHALL have parameter LUT_W, default 19, meaning the signed width of one LUT entry (sum of 8 signed 16-bit coefficients).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the sample width, which equals the number of bit-planes per frame.
REQ-003 The block SHALL have parameter OUT_W, default 38 (LUT_W+3+DATA_W), meaning the signed result width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a frame and coincides with the upstream shift-register load.
REQ-007 The block SHALL have port bit_valid, input, 1 bit: A7..A0 carry a valid bit-plane this cycle.
REQ-008 The block SHALL have ports A7..A0, input, 8 bits each: bit-plane addresses, where Ak[j] is the current bit of tap 8k+j, delivered MSB (sign) first.
REQ-009 The block SHALL have port lut_we, input, 1 bit: LUT write strobe.
REQ-010 The block SHALL have ports lut_sel (input, 3 bits) and lut_addr (input, 8 bits): LUT bank and entry for a write.
REQ-011 The block SHALL have port lut_wdata, input, LUT_W bits: signed LUT entry value.
REQ-012 The block SHALL have port y, output, OUT_W bits: signed filter output.
REQ-013 The block SHALL have port y_valid, output, 1 bit: one-cycle pulse marking y as new.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-015 The block SHALL contain 8 LUT banks of 256 x LUT_W entries; a write SHALL be accepted only when busy=0 and SHALL be silently dropped otherwise.
REQ-016 The FSM SHALL have states IDLE, ACCUM and FLUSH.
REQ-017 The FSM SHALL move IDLE->ACCUM on start, which clears the accumulator and sets the plane counter to 0.
REQ-018 In ACCUM, each bit_valid cycle SHALL register the 8 bank outputs LUTk[Ak] (stage 1) and increment the plane counter.
REQ-019 If bit_valid=0 in ACCUM, the counter and pipeline SHALL hold (stall) with no accumulation.
REQ-020 Stage 2 SHALL compute S = sign-extended sum of the 8 registered entries, then form acc = -S for plane 0 (sign) and acc = 2*acc + S for planes 1..DATA_W-1.
REQ-021 All arithmetic SHALL be two's complement at OUT_W bits; no saturation is needed, since the width is provably sufficient.
REQ-022 After plane DATA_W-1 is accepted, the FSM SHALL enter FLUSH, drain stage 2, then return to IDLE.
REQ-023 y SHALL update and y_valid SHALL pulse exactly 2 cycles after the last accepted bit_valid.
REQ-024 y SHALL hold its value until the next result.
REQ-025 bit_valid in IDLE or FLUSH SHALL be ignored.
REQ-026 start during ACCUM or FLUSH SHALL abort the current frame without y_valid and restart at plane 0 on the same cycle.
REQ-027 busy SHALL be 1 in ACCUM and FLUSH and 0 in IDLE.

Reset
REQ-028 Assertion of resetn=0 SHALL immediately force state IDLE, counter 0, accumulator 0, pipeline registers 0, y=0, y_valid=0 and busy=0, including mid-frame.
REQ-029 LUT contents SHALL NOT be reset and SHALL be retained across reset.
REQ-030 After resetn deasserts, the first frame SHALL require a fresh start.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration and the width constants LUT_W, DATA_W and OUT_W.
REQ-032 One sub-module da_lut_bank (256 x LUT_W, single write port, registered read) SHALL be instantiated 8 times.
REQ-033 The FSM, counter and accumulator SHALL reside in da_accum.

Verification
REQ-034 Scenario (one-tap ones): LUT0[a]=a, other banks 0; start, then 16 planes with A0=8'h01 and the rest 0 -> y=-1 and y_valid exactly 2 cycles after the 16th plane.
REQ-035 Scenario (LSB only): same LUTs; A0=8'h01 on plane 15 only -> y=+1.
REQ-036 Scenario (sign only): A0=8'h01 on plane 0 only -> y=-32768.
REQ-037 Scenario (stall): the REQ-034 stimulus with bit_valid dropped for 3 cycles after plane 7 -> y=-1, with y_valid delayed by 3 cycles.
REQ-038 Scenario (restart): start again after plane 9 of a frame, then a full LSB-only frame -> exactly one y_valid, with y=+1.
REQ-039 Scenario (reset/write guard): resetn=0 after plane 5 -> outputs 0 and busy=0 at once, and the next frame still gives y=-1 (LUT retained); lut_we while busy=1 leaves the LUT entry unchanged.
